// File: rtl/alt_vipcts131_common_control_packet_scheduler.sv
// Control packet scheduler: holds pending/active frame geometry, pulses the
// encoder's send once per frame and marks the last pixel with end_of_video.
module alt_vipcts131_common_control_packet_scheduler #(
  parameter int TOGGLE_FIELD = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cfg_width,
  input  logic [15:0] cfg_height,
  input  logic [3:0]  cfg_interlaced,
  input  logic        cfg_write,
  input  logic        cfg_enable,
  input  logic        enc_busy,
  input  logic        pix_xfer,
  output logic        enc_send,
  output logic [15:0] enc_width,
  output logic [15:0] enc_height,
  output logic [3:0]  enc_interlaced,
  output logic        end_of_video,
  output logic        frame_active,
  output logic [15:0] frame_count,
  output logic        err_cfg,
  output logic        err_pixel
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_STREAM} state_t;

  state_t      r_state;
  logic [15:0] r_pend_w, r_pend_h;
  logic [3:0]  r_pend_i;
  logic        r_pend_v;
  logic [15:0] r_act_w, r_act_h;
  logic [3:0]  r_act_i;
  logic        r_send, r_active, r_tog, r_err_cfg, r_err_pix;
  logic [15:0] r_col, r_row, r_fcnt;

  logic        w_cfg_ok, w_launch, w_last_col, w_last_row, w_eov;
  logic [15:0] w_src_w, w_src_h;
  logic [3:0]  w_src_i, w_next_i;

  assign w_cfg_ok   = cfg_write && (cfg_width != 16'd0) && (cfg_height != 16'd0);
  assign w_launch   = (r_state == S_IDLE) && cfg_enable && r_pend_v && !enc_busy;
  assign w_last_col = (r_col == r_act_w - 16'd1);
  assign w_last_row = (r_row == r_act_h - 16'd1);
  assign w_eov      = pix_xfer && (r_state == S_STREAM) && w_last_col && w_last_row;

  // A legal write in the launch cycle wins over the stored pending set.
  assign w_src_w = w_cfg_ok ? cfg_width      : r_pend_w;
  assign w_src_h = w_cfg_ok ? cfg_height     : r_pend_h;
  assign w_src_i = w_cfg_ok ? cfg_interlaced : r_pend_i;

  always_comb begin
    w_next_i = w_src_i;
    if (TOGGLE_FIELD == 1 && w_src_i[3])
      w_next_i[2] = cfg_write ? 1'b0 : r_tog;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_pend_w  <= '0;
      r_pend_h  <= '0;
      r_pend_i  <= '0;
      r_pend_v  <= 1'b0;
      r_act_w   <= '0;
      r_act_h   <= '0;
      r_act_i   <= '0;
      r_send    <= 1'b0;
      r_active  <= 1'b0;
      r_tog     <= 1'b0;
      r_err_cfg <= 1'b0;
      r_err_pix <= 1'b0;
      r_col     <= '0;
      r_row     <= '0;
      r_fcnt    <= '0;
    end else begin
      r_send <= 1'b0;
      if (cfg_write) begin
        if (w_cfg_ok) begin
          r_pend_w <= cfg_width;
          r_pend_h <= cfg_height;
          r_pend_i <= cfg_interlaced;
          r_pend_v <= 1'b1;
        end else begin
          r_err_cfg <= 1'b1;
        end
      end
      case (r_state)
        S_IDLE: begin
          if (pix_xfer) r_err_pix <= 1'b1;
          if (w_launch) begin
            r_state <= S_REQ;
            r_send  <= 1'b1;
            r_act_w <= w_src_w;
            r_act_h <= w_src_h;
            r_act_i <= w_next_i;
          end
        end
        S_REQ: begin
          if (pix_xfer) r_err_pix <= 1'b1;
          r_state  <= S_STREAM;
          r_active <= 1'b1;
          r_col    <= '0;
          r_row    <= '0;
        end
        S_STREAM: begin
          if (pix_xfer) begin
            if (w_last_col) begin
              r_col <= '0;
              if (w_last_row) begin
                r_state  <= S_IDLE;
                r_active <= 1'b0;
                r_fcnt   <= r_fcnt + 16'd1;
                r_row    <= '0;
              end else begin
                r_row <= r_row + 16'd1;
              end
            end else begin
              r_col <= r_col + 16'd1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
      // Field flips at every frame end; any cfg_write forces it back to 0.
      if (cfg_write)  r_tog <= 1'b0;
      else if (w_eov) r_tog <= ~r_tog;
    end
  end

  assign enc_send       = r_send;
  assign enc_width      = r_act_w;
  assign enc_height     = r_act_h;
  assign enc_interlaced = r_act_i;
  assign end_of_video   = w_eov;
  assign frame_active   = r_active;
  assign frame_count    = r_fcnt;
  assign err_cfg        = r_err_cfg;
  assign err_pixel      = r_err_pix;

endmodule
